div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 146 ++++++++++++++
 tb/tb_div_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider sequencer for DIV/DIVU
//
// Purpose: runs a 32-step restoring radix-2 divide for the execute stage,
// asks the hazard unit to stall while it is busy, and pulses ready once
// when the {remainder, quotient} result is valid.
//
// Optional feature: define DIV_ZERO_FAST_EN to send a zero divisor down a
// short path that returns 64'h0 two cycles after the request.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-low reset
//   start      in   1  begin a divide (only looked at in IDLE)
//   signed_div in   1  1 = DIV (two's complement), 0 = DIVU
//   opdata1    in  32  dividend
//   opdata2    in  32  divisor
//   annul      in   1  pipeline flush, aborts any operation
//   stall_div  out  1  stall request to the hazard unit
//   ready      out  1  one-cycle result-valid pulse
//   result     out 64  {remainder -> HI, quotient -> LO}

module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic        stall_div,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DIVZERO = 2'b01,
    S_ON      = 2'b10,
    S_END     = 2'b11
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] rem_q;
  logic [31:0] divisor_q;
  logic        sign_quo_q;
  logic        sign_rem_q;
  logic        ready_q;
  logic [63:0] result_q;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [33:0] diff;
  logic [64:0] rem_d;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    abs1 = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
    abs2 = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;

    // Trial subtract on the shifted partial remainder. The shifted upper
    // part is rem_q[64:31]; a 34-bit difference keeps the borrow clean.
    diff = rem_q[64:31] - {2'b00, divisor_q};
    if (!diff[33]) begin
      rem_d = {diff[32:0], rem_q[30:0], 1'b1};
    end else begin
      rem_d = {rem_q[63:0], 1'b0};
    end

    quo_fix = sign_quo_q ? (32'd0 - rem_q[31:0])  : rem_q[31:0];
    rem_fix = sign_rem_q ? (32'd0 - rem_q[63:32]) : rem_q[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 65'd0;
      divisor_q  <= 32'd0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= 64'h0;
    end else if (annul) begin
      // Flush wins over everything, including a start in IDLE.
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (start) begin
            cnt_q      <= 6'd0;
            rem_q      <= {33'd0, abs1};
            divisor_q  <= abs2;
            sign_quo_q <= signed_div & (opdata1[31] ^ opdata2[31]);
            sign_rem_q <= signed_div & opdata1[31];
`ifdef DIV_ZERO_FAST_EN
            if (opdata2 == 32'd0) begin
              state_q <= S_DIVZERO;
            end else begin
              state_q <= S_ON;
            end
`else
            state_q <= S_ON;
`endif
          end
        end
        S_ON: begin
          // Steps 0..31 run while cnt_q counts up; once all 32 are done
          // the signed fixup is registered together with the ready pulse.
          if (cnt_q == 6'd32) begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end else begin
            rem_q <= rem_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DIVZERO: begin
          result_q <= 64'h0;
          ready_q  <= 1'b1;
          state_q  <= S_END;
        end
        S_END: begin
          ready_q <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Drops in END so the stage advances in the same cycle ready pulses.
  assign stall_div = ((state_q == S_IDLE) && start && !annul) ||
                     (state_q == S_ON) || (state_q == S_DIVZERO);
  assign ready     = ready_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer

module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int total;
  int bad;

  div_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .stall_div  (stall_div),
    .ready      (ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to the ready pulse.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic chk_res,
                         input logic [63:0] exp_res);
    int lat;
    int stalls;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    #1;
    stalls = stall_div ? 1 : 0;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      if (stall_div) stalls++;
      tick();
      if (ready) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stalls"}, stalls, exp_lat + 1);
    chk({tag, "_stall_end"}, stall_div, 1'b0);
    if (chk_res) chk({tag, "_result"}, result, exp_res);
    tick();
    chk({tag, "_ready_drop"}, ready, 1'b0);
  endtask

  initial begin
    int   lat;
    logic seen;
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    annul      = 1'b0;

    #2;
    chk("rst_ready", ready, 1'b0);
    chk("rst_result", result, 64'h0);
    chk("rst_stall", stall_div, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // First request lands on the first edge after release.
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 1'b1, {32'd2, 32'd14});
    tick();
    tick();
    chk("hold_result", result, {32'd2, 32'd14});
    chk("idle_stall", stall_div, 1'b0);

    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, {32'h0, 32'h8000_0000});
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 1'b1, {32'h0, 32'hFFFF_FFFF});
    run_div("divu_5_9", 1'b0, 32'd5, 32'd9, 33, 1'b1, {32'd5, 32'd0});
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 1'b1, {32'd1, 32'hFFFF_FFFD});

    // Annul at counter=10.
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | ready;
    end
    annul = 1'b1;
    tick();
    annul = 1'b0;
    chk("annul_ready", ready, 1'b0);
    chk("annul_stall", stall_div, 1'b0);
    chk("annul_result", result, {32'd1, 32'hFFFF_FFFD});
    run_div("after_annul", 1'b0, 32'd1000, 32'd3, 33, 1'b1, {32'd1, 32'd333});
    chk("annul_no_ready", seen, 1'b0);

`ifdef DIV_ZERO_FAST_EN
    run_div("divz", 1'b0, 32'd5, 32'd0, 1, 1'b1, 64'h0);
`else
    run_div("divz", 1'b0, 32'd5, 32'd0, 33, 1'b0, 64'h0);
`endif

    // Reset at counter=20.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_result", result, 64'h0);
    chk("midrst_stall", stall_div, 1'b0);
    tick();
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | ready;
    end
    chk("midrst_no_ready", seen, 1'b0);

    // start held during ON with other operands must be ignored.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    tick();
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    lat     = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 11) start = 1'b0;
      tick();
      if (ready) begin
        lat = k;
        break;
      end
    end
    chk("ign_latency", lat, 33);
    chk("ign_result", result, {32'd2, 32'd14});
    tick();

    // annul beats start in IDLE.
    start = 1'b1;
    annul = 1'b1;
    #1;
    chk("prio_stall_req", stall_div, 1'b0);
    tick();
    start = 1'b0;
    annul = 1'b0;
    #1;
    chk("prio_stall_after", stall_div, 1'b0);
    chk("prio_ready", ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
